// File: rtl/rng_pkg.sv
// Shared definitions for the rng accumulator and its byte server.
package rng_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KICK = 2'd1,
      WAIT = 2'd2,
      SEND = 2'd3
   } rng_srv_state_t;

   localparam int unsigned RNG_BYTES   = 8;
   localparam int unsigned RNG_MAX_REQ = 64;
   localparam int unsigned RNG_TIMEOUT = 64;

endpackage

// File: rtl/rng_byte_server.sv
// Serves byte-count requests by triggering the rng accumulator and streaming
// each result word out byte by byte; the word buffer is wiped on completion,
// timeout and reset.
module rng_byte_server
   import rng_pkg::*;
#(
   parameter int unsigned BYTES   = RNG_BYTES,
   parameter int unsigned MAX_REQ = RNG_MAX_REQ,
   parameter int unsigned TIMEOUT = RNG_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [$clog2(MAX_REQ+1)-1:0] req_len,
   output logic                         rng_start,
   input  logic [8*BYTES-1:0]           rng_result,
   input  logic                         rng_valid,
   output logic [7:0]                   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic                         err
);

   localparam int unsigned LEN_W  = $clog2(MAX_REQ + 1);
   localparam int unsigned IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned TMR_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned WORD_W = 8 * BYTES;

   rng_srv_state_t    state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
   logic [TMR_W-1:0]  timer_q, timer_d;

   logic       req_ready_q, req_ready_d;
   logic       rng_start_q, rng_start_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic       out_last_q, out_last_d;
   logic       busy_q, busy_d;
   logic       err_q, err_d;

   // State, datapath and registered outputs; reset wipes the buffer at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         remaining_q <= '0;
         byte_idx_q  <= '0;
         timer_q     <= '0;
         req_ready_q <= 1'b1;
         rng_start_q <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         remaining_q <= remaining_d;
         byte_idx_q  <= byte_idx_d;
         timer_q     <= timer_d;
         req_ready_q <= req_ready_d;
         rng_start_q <= rng_start_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic; outputs are decoded from next-state values so the
   // registered copies line up with the state they describe.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      remaining_d = remaining_q;
      byte_idx_d  = byte_idx_q;
      timer_d     = timer_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if ((req_len == '0) || (req_len > LEN_W'(MAX_REQ))) begin
                  err_d = 1'b1;
               end else begin
                  remaining_d = req_len;
                  state_d     = KICK;
               end
            end
         end
         KICK: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (rng_valid) begin
               word_d     = rng_result;
               byte_idx_d = '0;
               state_d    = SEND;
            end else if (timer_q == TMR_W'(TIMEOUT - 2)) begin
               // timer would reach TIMEOUT-1: give up and scrub
               err_d   = 1'b1;
               word_d  = '0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         SEND: begin
            if (out_ready) begin
               remaining_d = remaining_q - LEN_W'(1);
               byte_idx_d  = byte_idx_q + IDX_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  word_d  = '0;
                  state_d = IDLE;
               end else if (byte_idx_q == IDX_W'(BYTES - 1)) begin
                  state_d = KICK;
               end
            end
         end
         default: begin
            state_d = IDLE;
            word_d  = '0;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      rng_start_d = (state_d == KICK);
      out_valid_d = (state_d == SEND);
      out_last_d  = (state_d == SEND) && (remaining_d == LEN_W'(1));
      out_data_d  = (state_d == SEND) ? word_d[{byte_idx_d, 3'b000} +: 8] : 8'h00;
   end

   assign req_ready = req_ready_q;
   assign rng_start = rng_start_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rng_byte_server.sv
// Bench for rng_byte_server: a latency model of the accumulator plus a byte
// scoreboard filled at request time and drained against the output stream.
module tb_rng_byte_server;

   localparam int unsigned BYTES   = 8;
   localparam int unsigned MAX_REQ = 64;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned LEN_W   = 7;
   localparam int unsigned RNG_LAT = 10;
   localparam logic [63:0] RNG_WORD = 64'h0807060504030201;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [LEN_W-1:0] req_len = '0;
   logic             rng_start;
   logic [63:0]      rng_result = RNG_WORD;
   logic             rng_valid;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_last;
   logic             busy;
   logic             err;

   rng_byte_server #(.BYTES(BYTES), .MAX_REQ(MAX_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
      .rng_start(rng_start), .rng_result(rng_result), .rng_valid(rng_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // accumulator model: pulse rng_valid RNG_LAT cycles after rng_start
   logic rng_mute = 1'b0;
   int   rng_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rng_cnt   <= 0;
         rng_valid <= 1'b0;
      end else begin
         rng_valid <= 1'b0;
         if (rng_start && !rng_mute) rng_cnt <= RNG_LAT;
         else if (rng_cnt != 0) begin
            rng_cnt <= rng_cnt - 1;
            if (rng_cnt == 1) rng_valid <= 1'b1;
         end
      end
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int n_start, n_err, n_valid, n_ready_busy, hold_bad, cyc, start_cyc, err_cyc;
   bit prev_stall;
   logic [7:0] prev_data;
   logic prev_last;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic clear_stats();
      exp_q.delete(); got_q.delete();
      n_start = 0; n_err = 0; n_valid = 0; n_ready_busy = 0; hold_bad = 0;
      cyc = 0; start_cyc = -1000; err_cyc = 0; prev_stall = 0;
   endtask

   // observe mid-cycle, then advance to just after the next rising edge
   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (rng_start) begin n_start++; start_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
      if (out_valid) n_valid++;
      if (busy && req_ready) n_ready_busy++;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
         hold_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      @(posedge clk); #1;
   endtask

   task automatic send_req(input int len, input bit push);
      req_valid = 1'b1;
      req_len   = LEN_W'(len);
      cycle();
      req_valid = 1'b0;
      if (push)
         for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), 8'((i % BYTES) + 1)});
   endtask

   task automatic run_idle(input int budget, output bit timed_out);
      int n = 0;
      while (busy && n < budget) begin cycle(); n++; end
      timed_out = busy;
   endtask

   task automatic test_reset();
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else pass_cnt++;
      total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else pass_cnt++;
      total_cnt++; if (rng_start !== 1'b0) $display("FAIL reset_rng_start got %b want 0", rng_start); else pass_cnt++;
      total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
   endtask

   task automatic test_len3();
      bit to;
      logic [8:0] e, g;
      clear_stats();
      out_ready = 1'b1;
      send_req(3, 1);
      total_cnt++; if (rng_start !== 1'b1) $display("FAIL len3_start_latency got %b want 1", rng_start); else pass_cnt++;
      run_idle(200, to);
      total_cnt++; if (to) $display("FAIL len3_timeout busy got 1 want 0"); else pass_cnt++;
      cycle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL len3_byte got none want %h", e);
         else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL len3_byte got %h want %h", g, e); else pass_cnt++;
         end
      end
      total_cnt++; if (got_q.size() != 0) $display("FAIL len3_extra got %0d want 0", got_q.size()); else pass_cnt++;
      total_cnt++; if (n_start != 1) $display("FAIL len3_starts got %0d want 1", n_start); else pass_cnt++;
      total_cnt++; if (dut.word_q !== 64'h0) $display("FAIL len3_wiped got %h want 0", dut.word_q); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL len3_ready got %b want 1", req_ready); else pass_cnt++;
   endtask

   task automatic test_len10();
      bit to;
      logic [8:0] e, g;
      clear_stats();
      out_ready = 1'b1;
      send_req(10, 1);
      run_idle(400, to);
      total_cnt++; if (to) $display("FAIL len10_timeout busy got 1 want 0"); else pass_cnt++;
      cycle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL len10_byte got none want %h", e);
         else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL len10_byte got %h want %h", g, e); else pass_cnt++;
         end
      end
      total_cnt++; if (got_q.size() != 0) $display("FAIL len10_extra got %0d want 0", got_q.size()); else pass_cnt++;
      total_cnt++; if (n_start != 2) $display("FAIL len10_starts got %0d want 2", n_start); else pass_cnt++;
      total_cnt++; if (n_ready_busy != 0) $display("FAIL len10_ready_busy got %0d want 0", n_ready_busy); else pass_cnt++;
   endtask

   task automatic test_stall();
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int k = 0;
      logic [8:0] e, g;
      clear_stats();
      out_ready = 1'b1;
      send_req(4, 1);
      while (busy && k < 400) begin
         out_ready = pat[k % 4];
         cycle();
         k++;
      end
      total_cnt++; if (busy) $display("FAIL stall_timeout busy got 1 want 0"); else pass_cnt++;
      out_ready = 1'b1;
      cycle();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL stall_byte got none want %h", e);
         else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL stall_byte got %h want %h", g, e); else pass_cnt++;
         end
      end
      total_cnt++; if (got_q.size() != 0) $display("FAIL stall_extra got %0d want 0", got_q.size()); else pass_cnt++;
      total_cnt++; if (hold_bad != 0) $display("FAIL stall_hold got %0d unstable cycles want 0", hold_bad); else pass_cnt++;
   endtask

   task automatic test_reject();
      int lens [2] = '{0, 65};
      for (int i = 0; i < 2; i++) begin
         clear_stats();
         send_req(lens[i], 0);
         repeat (3) cycle();
         total_cnt++; if (n_err != 1) $display("FAIL reject_err len %0d got %0d want 1", lens[i], n_err); else pass_cnt++;
         total_cnt++; if (n_start != 0) $display("FAIL reject_start len %0d got %0d want 0", lens[i], n_start); else pass_cnt++;
         total_cnt++; if (busy !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL reject_idle len %0d got busy %b ready %b want 0 1", lens[i], busy, req_ready);
         else pass_cnt++;
      end
   endtask

   task automatic test_timeout();
      bit to;
      clear_stats();
      rng_mute = 1'b1;
      out_ready = 1'b1;
      send_req(8, 0);
      run_idle(300, to);
      total_cnt++; if (to) $display("FAIL tmo_stuck busy got 1 want 0"); else pass_cnt++;
      repeat (2) cycle();
      total_cnt++; if (n_err != 1) $display("FAIL tmo_err got %0d want 1", n_err); else pass_cnt++;
      total_cnt++; if (err_cyc - start_cyc != TIMEOUT)
         $display("FAIL tmo_delay got %0d want %0d", err_cyc - start_cyc, TIMEOUT);
      else pass_cnt++;
      total_cnt++; if (n_valid != 0) $display("FAIL tmo_valid got %0d want 0", n_valid); else pass_cnt++;
      total_cnt++; if (dut.word_q !== 64'h0) $display("FAIL tmo_wiped got %h want 0", dut.word_q); else pass_cnt++;
      rng_mute = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit to;
      int k = 0;
      logic [8:0] g;
      clear_stats();
      out_ready = 1'b1;
      send_req(8, 0);
      while (got_q.size() < 2 && k < 200) begin cycle(); k++; end
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL rstmid_in_send got %b want 1", out_valid); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00)
         $display("FAIL rstmid_outs got v%b l%b d%h want 0 0 00", out_valid, out_last, out_data);
      else pass_cnt++;
      total_cnt++; if (busy !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL rstmid_state got busy %b ready %b want 0 1", busy, req_ready);
      else pass_cnt++;
      total_cnt++; if (dut.word_q !== 64'h0) $display("FAIL rstmid_wiped got %h want 0", dut.word_q); else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_stats();
      send_req(1, 0);
      run_idle(200, to);
      cycle();
      total_cnt++; if (to) $display("FAIL rstmid_after_stuck busy got 1 want 0"); else pass_cnt++;
      total_cnt++;
      if (got_q.size() != 1) $display("FAIL rstmid_after_count got %0d want 1", got_q.size());
      else begin
         g = got_q.pop_front();
         if (g !== 9'h101) $display("FAIL rstmid_after_byte got %h want 101", g); else pass_cnt++;
      end
      total_cnt++; if (n_start != 1) $display("FAIL rstmid_after_starts got %0d want 1", n_start); else pass_cnt++;
   endtask

   initial begin
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_len3();
      test_len10();
      test_stall();
      test_reject();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
